// File: rtl/dp_pkg.sv
// Shared definitions for the bus datapath: sequencer states and watchdog limit.
package dp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DATA,
    ST_DROP
  } state_t;

  localparam int unsigned TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/prefetch_fifo.sv
// Prefetch queue: DEPTH-entry FIFO with synchronous flush (flush beats push/pop).
// Latency: push visible at head next cycle; backpressure: push when full accepted only with a pop.
module prefetch_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/bus_datapath.sv
// Fetch/data bus sequencer with prefetch queue and stack pointer; BUS_TIMEOUT_EN adds a bus watchdog.
// Latency: bus_ack to ir_valid/rd_valid 1 cycle; backpressure: op waits for IDLE, prefetch stalls when queue full.
module bus_datapath
  import dp_pkg::*;
#(
  parameter int          DATA_W   = 8,
  parameter int          ADDR_W   = 16,
  parameter int          PF_DEPTH = 2,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [DATA_W-1:0] ir_data,
  output logic [ADDR_W-1:0] ir_pc,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
  input  logic              op_valid,
  input  logic              op_we,
  input  logic [ADDR_W-1:0] op_addr,
  input  logic [DATA_W-1:0] op_wdata,
  output logic              op_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              sp_inc,
  input  logic              sp_dec,
  input  logic              sp_load,
  input  logic [ADDR_W-1:0] sp_load_val,
  output logic [ADDR_W-1:0] sp,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              bus_err
);

  typedef struct packed {
    logic [DATA_W-1:0] dat;
    logic [ADDR_W-1:0] pc;
  } pf_entry_t;

  state_t            state;
  logic [ADDR_W-1:0] fetch_pc;
  pf_entry_t         push_ent;
  pf_entry_t         head_ent;
  logic              pf_push;
  logic              pf_pop;
  logic              pf_empty;
  logic              pf_full;
  logic              tmo_hit;

  // A redirect coinciding with the fetch ack makes that opcode stale.
  assign pf_push  = (state == ST_FETCH) && bus_ack && !pc_load;
  assign pf_pop   = ir_valid && ir_ready;
  assign push_ent = '{dat: bus_rdata, pc: bus_addr};

  prefetch_fifo #(
    .WIDTH($bits(pf_entry_t)),
    .DEPTH(PF_DEPTH)
  ) u_pf (
    .clk     (clk),
    .rst     (rst),
    .flush   (pc_load),
    .push    (pf_push),
    .push_dat(push_ent),
    .pop     (pf_pop),
    .pop_dat (head_ent),
    .empty   (pf_empty),
    .full    (pf_full)
  );

  assign ir_valid = !pf_empty;
  assign ir_data  = head_ent.dat;
  assign ir_pc    = head_ent.pc;
  assign op_ready = !rst && (state == ST_IDLE) && op_valid;

`ifdef BUS_TIMEOUT_EN
  logic [7:0] tmo_cnt;

  // tmo_cnt counts cycles already spent waiting, so the abort lands on the last allowed cycle.
  assign tmo_hit = (state != ST_IDLE) && !bus_ack && (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
      bus_err <= 1'b0;
    end else begin
      tmo_cnt <= (state == ST_IDLE || bus_ack) ? 8'd0 : tmo_cnt + 8'd1;
      if (tmo_hit) bus_err <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      fetch_pc  <= ADDR_W'(RESET_PC);
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      rd_valid <= 1'b0;
      if (pc_load) fetch_pc <= pc_load_val;
      case (state)
        ST_IDLE: begin
          if (op_valid) begin
            state     <= ST_DATA;
            bus_req   <= 1'b1;
            bus_we    <= op_we;
            bus_addr  <= op_addr;
            bus_wdata <= op_wdata;
          end else if (!pf_full && !pc_load) begin
            state    <= ST_FETCH;
            bus_req  <= 1'b1;
            bus_we   <= 1'b0;
            bus_addr <= fetch_pc;
          end
        end
        ST_FETCH: begin
          if (bus_ack) begin
            state   <= ST_IDLE;
            bus_req <= 1'b0;
            if (!pc_load) fetch_pc <= fetch_pc + 1'b1;
          end else if (tmo_hit) begin
            state   <= ST_IDLE;
            bus_req <= 1'b0;
          end else if (pc_load) begin
            state <= ST_DROP;
          end
        end
        ST_DATA: begin
          if (bus_ack) begin
            state   <= ST_IDLE;
            bus_req <= 1'b0;
            if (!bus_we) begin
              rd_valid <= 1'b1;
              rd_data  <= bus_rdata;
            end
          end else if (tmo_hit) begin
            state   <= ST_IDLE;
            bus_req <= 1'b0;
            if (!bus_we) begin
              rd_valid <= 1'b1;
              rd_data  <= '1;
            end
          end
        end
        ST_DROP: begin
          if (bus_ack || tmo_hit) begin
            state   <= ST_IDLE;
            bus_req <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                    sp <= '0;
    else if (sp_load)           sp <= sp_load_val;
    else if (sp_inc && !sp_dec) sp <= sp + 1'b1;
    else if (sp_dec && !sp_inc) sp <= sp - 1'b1;
  end

endmodule

// File: tb/tb_bus_datapath.sv
// Directed bench for bus_datapath with a scripted bus responder and opcode/read-data scoreboards.
module tb_bus_datapath;

  localparam int DW = 8;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          ir_valid, ir_ready;
  logic [DW-1:0] ir_data;
  logic [AW-1:0] ir_pc;
  logic          pc_load;
  logic [AW-1:0] pc_load_val;
  logic          op_valid, op_we, op_ready;
  logic [AW-1:0] op_addr;
  logic [DW-1:0] op_wdata;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          sp_inc, sp_dec, sp_load;
  logic [AW-1:0] sp_load_val, sp;
  logic          bus_req, bus_we, bus_ack, bus_err;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata, bus_rdata;

  always #5 clk = ~clk;

  bus_datapath #(
    .DATA_W(DW), .ADDR_W(AW), .PF_DEPTH(2), .RESET_PC(32'h0100)
  ) dut (
    .clk(clk), .rst(rst),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_data(ir_data), .ir_pc(ir_pc),
    .pc_load(pc_load), .pc_load_val(pc_load_val),
    .op_valid(op_valid), .op_we(op_we), .op_addr(op_addr), .op_wdata(op_wdata),
    .op_ready(op_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .sp_inc(sp_inc), .sp_dec(sp_dec), .sp_load(sp_load), .sp_load_val(sp_load_val), .sp(sp),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] dat;
  } ir_exp_t;

  ir_exp_t       ir_q[$];
  logic [DW-1:0] rd_q[$];
  int            n_chk = 0;
  int            n_fail = 0;
  int            pushes = 0;
  int            pops = 0;
  int            n_accept = 0;
  logic [AW-1:0] model_pc = 16'h0100;
  logic [AW-1:0] last_pop_pc = '0;
  bit            ack_en = 1'b0;
  int            ack_delay = 0;
  int            wait_cnt = 0;
  bit            data_pend = 1'b0;
  bit            data_we_exp = 1'b0;
  logic [AW-1:0] data_addr_exp = '0;
  logic [DW-1:0] data_wdata_exp = '0;
  logic [DW-1:0] data_rdata = '0;
  bit            drop_pend = 1'b0;
  bit            prev_held = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic          prev_we = 1'b0;
  logic [DW-1:0] prev_wdata = '0;

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: respond to the bus, score the handshakes that the coming edge will take, then advance.
  task automatic step();
    ir_exp_t e;
    bus_ack   = ack_en && bus_req && (wait_cnt >= ack_delay);
    bus_rdata = data_pend ? data_rdata : mem_rd(bus_addr);
    #1;
    if (bus_req && prev_held) begin
      chk("bus_addr_stable", 32'(bus_addr), 32'(prev_addr));
      chk("bus_we_stable", 32'(bus_we), 32'(prev_we));
      chk("bus_wdata_stable", 32'(bus_wdata), 32'(prev_wdata));
    end
    prev_held  = bus_req && !bus_ack;
    prev_addr  = bus_addr;
    prev_we    = bus_we;
    prev_wdata = bus_wdata;
    if (ir_valid && ir_ready) begin
      chk("ir_pop_expected", 32'(ir_q.size() != 0), 32'd1);
      if (ir_q.size() != 0) begin
        e = ir_q.pop_front();
        chk("ir_pc", 32'(ir_pc), 32'(e.pc));
        chk("ir_data", 32'(ir_data), 32'(e.dat));
        last_pop_pc = ir_pc;
        pops++;
      end
    end
    if (bus_req && bus_ack) begin
      if (data_pend) begin
        chk("data_addr", 32'(bus_addr), 32'(data_addr_exp));
        chk("data_we", 32'(bus_we), 32'(data_we_exp));
        if (data_we_exp) chk("data_wdata", 32'(bus_wdata), 32'(data_wdata_exp));
        else rd_q.push_back(data_rdata);
        data_pend = 1'b0;
      end else begin
        chk("fetch_we", 32'(bus_we), 32'd0);
        if (drop_pend) drop_pend = 1'b0;
        else begin
          chk("fetch_addr", 32'(bus_addr), 32'(model_pc));
          if (!pc_load) begin
            ir_q.push_back('{pc: model_pc, dat: mem_rd(model_pc)});
            model_pc++;
            pushes++;
          end
        end
      end
      wait_cnt = 0;
    end else if (bus_req) begin
      wait_cnt++;
    end
    if (pc_load) begin
      if (bus_req && !bus_ack && !data_pend) drop_pend = 1'b1;
      ir_q.delete();
      model_pc = pc_load_val;
    end
    if (op_valid && op_ready) begin
      data_pend      = 1'b1;
      data_we_exp    = op_we;
      data_addr_exp  = op_addr;
      data_wdata_exp = op_wdata;
      n_accept++;
    end
    @(posedge clk);
    #1;
    if (rd_valid) begin
      chk("rd_valid_expected", 32'(rd_q.size() != 0), 32'd1);
      if (rd_q.size() != 0) chk("rd_data", 32'(rd_data), 32'(rd_q.pop_front()));
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, p0, cnt;
    rst = 1'b1; ir_ready = 1'b0; pc_load = 1'b0; pc_load_val = '0;
    op_valid = 1'b1; op_we = 1'b0; op_addr = 16'h1111; op_wdata = '0;
    sp_inc = 1'b0; sp_dec = 1'b0; sp_load = 1'b0; sp_load_val = '0;
    bus_ack = 1'b0; bus_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ir_valid", 32'(ir_valid), 32'd0);
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_sp", 32'(sp), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_op_ready", 32'(op_ready), 32'd0);
    op_valid = 1'b0;
    rst = 1'b0;
    step();
    chk("first_bus_req", 32'(bus_req), 32'd1);
    chk("first_bus_addr", 32'(bus_addr), 32'h0100);

    // Back-to-back fetch stream from RESET_PC
    ir_ready = 1'b1; ack_en = 1'b1;
    repeat (24) step();
    chk("stream_pops", 32'(pops >= 8), 32'd1);
    chk("stream_last_pc", 32'(last_pop_pc), 32'(16'h0100 + 16'(pops - 1)));

    // Data write: no read-data pulse expected
    op_valid = 1'b1; op_we = 1'b1; op_addr = 16'h8001; op_wdata = 8'h3C;
    a0 = n_accept;
    for (int i = 0; i < 20 && n_accept == a0; i++) step();
    op_valid = 1'b0;
    chk("write_accepted", 32'(n_accept - a0), 32'd1);
    for (int i = 0; i < 20 && data_pend; i++) step();
    chk("write_done", 32'(data_pend), 32'd0);

    // Data read queued behind an outstanding fetch
    ack_delay = 2;
    for (int i = 0; i < 20 && !(bus_req && !data_pend && wait_cnt == 0); i++) step();
    chk("fetch_pending", 32'(bus_req && !data_pend), 32'd1);
    op_valid = 1'b1; op_we = 1'b0; op_addr = 16'hC000; data_rdata = 8'h5A;
    p0 = pushes; a0 = n_accept;
    step();
    chk("op_blocked_by_fetch", 32'(op_ready), 32'd0);
    for (int i = 0; i < 20 && n_accept == a0; i++) step();
    op_valid = 1'b0;
    chk("read_accepted", 32'(n_accept - a0), 32'd1);
    chk("fetch_before_data", 32'(pushes > p0), 32'd1);
    for (int i = 0; i < 20 && !rd_valid; i++) step();
    chk("rd_valid_seen", 32'(rd_valid), 32'd1);
    chk("rd_data_5a", 32'(rd_data), 32'h5A);
    step();
    chk("rd_valid_pulse", 32'(rd_valid), 32'd0);
    chk("rd_data_held", 32'(rd_data), 32'h5A);

    // Redirect in the same cycle as a fetch ack
    ack_delay = 0;
    for (int i = 0; i < 20 && !(bus_req && !data_pend); i++) step();
    pc_load = 1'b1; pc_load_val = 16'h0050; p0 = pops;
    step();
    pc_load = 1'b0;
    chk("flush_same_ack", 32'(ir_valid), 32'd0);
    for (int i = 0; i < 20 && pops == p0; i++) step();
    chk("redirect_ack_pc", 32'(last_pop_pc), 32'h0050);

    // Redirect during a delayed fetch: response dropped
    ack_delay = 3;
    for (int i = 0; i < 20 && !(bus_req && !data_pend && wait_cnt == 0); i++) step();
    pc_load = 1'b1; pc_load_val = 16'h0038; p0 = pops;
    step();
    pc_load = 1'b0;
    chk("flush_drop", 32'(ir_valid), 32'd0);
    chk("drop_waits_ack", 32'(bus_req), 32'd1);
    for (int i = 0; i < 30 && pops == p0; i++) step();
    chk("redirect_drop_pc", 32'(last_pop_pc), 32'h0038);

    // Queue fills and prefetch stops
    ack_delay = 0; ir_ready = 1'b0;
    pc_load = 1'b1; pc_load_val = 16'h0200;
    step();
    pc_load = 1'b0; p0 = pushes;
    repeat (15) step();
    chk("full_fetch_count", 32'(pushes - p0), 32'd2);
    chk("full_no_req", 32'(bus_req), 32'd0);
    chk("full_head_pc", 32'(ir_pc), 32'h0200);
    ir_ready = 1'b1;
    step();
    ir_ready = 1'b0;
    for (int i = 0; i < 5 && !bus_req; i++) step();
    chk("refetch_after_pop", 32'(bus_req), 32'd1);

    // Stack pointer
    sp_dec = 1'b1; step(); sp_dec = 1'b0;
    chk("sp_wrap_dec", 32'(sp), 32'hFFFF);
    sp_inc = 1'b1; sp_dec = 1'b1; step(); sp_dec = 1'b0;
    chk("sp_inc_dec_hold", 32'(sp), 32'hFFFF);
    sp_load = 1'b1; sp_load_val = 16'h1234; step(); sp_load = 1'b0;
    chk("sp_load_wins", 32'(sp), 32'h1234);
    step(); sp_inc = 1'b0;
    chk("sp_inc", 32'(sp), 32'h1235);

`ifdef BUS_TIMEOUT_EN
    // Unanswered read aborts after 255 cycles
    ir_ready = 1'b1;
    op_valid = 1'b1; op_we = 1'b0; op_addr = 16'h4000; a0 = n_accept;
    for (int i = 0; i < 20 && n_accept == a0; i++) step();
    op_valid = 1'b0; ack_en = 1'b0; data_pend = 1'b0;
    rd_q.push_back(8'hFF);
    cnt = 0;
    for (int i = 0; i < 400 && !rd_valid; i++) begin
      if (bus_req) cnt++;
      step();
    end
    chk("tmo_cycles", 32'(cnt), 32'd255);
    chk("tmo_bus_err", 32'(bus_err), 32'd1);
    chk("tmo_rd_data", 32'(rd_data), 32'hFF);
    ack_en = 1'b1;
`endif

    ir_ready = 1'b0;
    repeat (10) step();
    chk("end_ir_valid", 32'(ir_valid), 32'(ir_q.size() != 0));
    chk("end_rd_q_empty", 32'(rd_q.size()), 32'd0);
    chk("end_no_data_pend", 32'(data_pend), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_datapath.md
BUS_DATAPATH -- requirements
Module: bus_datapath

Interface
REQ-001 Parameters: DATA_W, default 8, data and opcode width; ADDR_W, default 16, address width; PF_DEPTH, default 2, prefetch queue entries (power of two, >=1); RESET_PC, default 0, PC value after reset.
REQ-002 Ports, one per line, name direction width meaning:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ir_valid  out  1  opcode available at queue head.
- ir_ready  in  1  decoder consumes head opcode.
- ir_data  out  DATA_W  head opcode.
- ir_pc  out  ADDR_W  address the head opcode was fetched from.
- pc_load  in  1  redirect fetch stream.
- pc_load_val  in  ADDR_W  redirect target.
- op_valid  in  1  data memory request.
- op_we  in  1  1 = write, 0 = read.
- op_addr  in  ADDR_W  data address (MAR).
- op_wdata  in  DATA_W  write data (MDR).
- op_ready  out  1  request accepted this cycle.
- rd_valid  out  1  one-cycle pulse, read data returned.
- rd_data  out  DATA_W  read data (MDR), held until next read completes.
- sp_inc, sp_dec, sp_load  in  1 each  stack pointer controls.
- sp_load_val  in  ADDR_W  SP load value.
- sp  out  ADDR_W  stack pointer.
- bus_req  out  1  bus transaction pending.
- bus_we  out  1  transaction is a write.
- bus_addr  out  ADDR_W  transaction address.
- bus_wdata  out  DATA_W  transaction write data.
- bus_ack  in  1  transaction completes this cycle.
- bus_rdata  in  DATA_W  read data, valid with bus_ack.
- bus_err  out  1  sticky timeout flag (BUS_TIMEOUT_EN only; tied 0 otherwise).

Function
REQ-003 FSM states: IDLE, FETCH, DATA, DROP; at most one bus transaction outstanding.
REQ-004 IDLE: op_valid -> DATA (op_ready=1 same cycle, op captured); else queue not full and no pc_load -> FETCH at fetch PC; else stay.
REQ-005 Data requests SHALL have priority over prefetch at every IDLE decision.
REQ-006 bus_req, bus_we, bus_addr, bus_wdata SHALL stay stable from issue until the bus_ack cycle inclusive.
REQ-007 FETCH + bus_ack: push {bus_rdata, addr} to queue, fetch PC += 1 modulo 2^ADDR_W, -> IDLE.
REQ-008 DATA + bus_ack: read -> rd_data=bus_rdata, rd_valid=1 next cycle; write -> no rd_valid; -> IDLE.
REQ-009 pc_load: queue flushed, ir_valid=0 next cycle, fetch PC=pc_load_val; if in FETCH without bus_ack -> DROP; DROP discards response and -> IDLE on bus_ack.
REQ-010 pc_load in the same cycle as a FETCH bus_ack: response discarded, no push, fetch PC=pc_load_val.
REQ-011 pc_load during DATA SHALL NOT affect the data transaction.
REQ-012 Queue: ir_valid=!empty; pop on ir_valid&&ir_ready; simultaneous push and pop legal when full; no prefetch issued when full; latency bus_ack -> ir_valid is 1 cycle when empty.
REQ-013 SP: sp_load wins; else sp_inc&&sp_dec -> unchanged; else +1/-1 modulo 2^ADDR_W.

Reset
REQ-014 rst: state IDLE, queue empty, ir_valid=0, fetch PC=RESET_PC, sp=0, rd_data=0, rd_valid=0, op_ready=0, bus_req=0, bus_err=0; in-flight transaction abandoned.
REQ-015 First bus_req SHALL assert one cycle after rst deasserts, fetching RESET_PC.

Configuration
REQ-016 Macro BUS_TIMEOUT_EN defined: 8-bit counter; FETCH/DATA/DROP held 255 cycles without bus_ack -> abort to IDLE, bus_err=1 until rst; aborted read yields rd_valid=1, rd_data all ones; aborted fetch pushes nothing, PC unchanged.
REQ-017 Macro undefined: no counter, wait indefinitely, bus_err tied 0.

Structure
REQ-018 Shared package dp_pkg: FSM state enum, timeout constant 255.
REQ-019 Sub-module prefetch_fifo (parameters DATA_W+ADDR_W, PF_DEPTH) holds the queue with flush input.

Verification
REQ-020 Reset, RESET_PC=0x0100, bus_ack every cycle, ir_ready=1 -> ir_pc 0x0100, 0x0101, ... consecutively.
REQ-021 ir_ready=0, PF_DEPTH=2 -> exactly 2 fetches, then bus_req=0 until pop.
REQ-022 op read 0xC000 while fetch outstanding, bus_rdata 0x5A -> data issued after fetch ack; rd_valid pulse, rd_data=0x5A.
REQ-023 pc_load 0x0038 during fetch with ack delayed 3 cycles -> response dropped, next ir_pc=0x0038.
REQ-024 sp=0x0000, sp_dec -> 0xFFFF; sp_inc+sp_dec -> unchanged; sp_load 0x1234 with sp_inc -> 0x1234.
REQ-025 BUS_TIMEOUT_EN, read, no ack -> after 255 cycles bus_err=1, rd_data=0xFF, rd_valid pulse.
